// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the FPU datapaths (multiplier and divider):
//   - IEEE-754 single-precision field widths and exponent bias
//   - canonical quiet NaN and +infinity encodings
//   - divider FSM state encoding
//   - fp_unpack(): splits a packed word into sign/exponent/fraction and
//     classifies it. Denormals are reported as zero because the datapaths
//     flush them.
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int WORD_W = 1 + EXP_W + FRAC_W;

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    SPECIAL,
    DIVIDE,
    ROUND
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [FRAC_W-1:0] frac;
    logic              is_zero;  // exponent field 0 (true zero or flushed denormal)
    logic              is_inf;
    logic              is_nan;
  } fp_fields_t;

  function automatic fp_fields_t fp_unpack(input logic [WORD_W-1:0] x);
    fp_fields_t f;
    f.sign    = x[WORD_W-1];
    f.expo    = x[WORD_W-2:FRAC_W];
    f.frac    = x[FRAC_W-1:0];
    f.is_zero = (f.expo == '0);
    f.is_inf  = (f.expo == '1) && (f.frac == '0);
    f.is_nan  = (f.expo == '1) && (f.frac != '0);
    return f;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// -----------------------------------------------------------------------------
// fp_round_rne
// Combinational round-to-nearest-even and pack stage.
// The caller supplies an already normalised significand (hidden bit implied,
// only the stored fraction is passed), guard and sticky bits, and a biased
// exponent in two extra bits of signed headroom.
// Ports:
//   sign       result sign
//   frac       normalised fraction before rounding
//   guard      first bit below the fraction LSB
//   sticky     OR of every bit below guard (including any remainder)
//   exp_in     biased exponent, signed, EXP_W+2 bits
//   result     packed IEEE word (saturates to +/-inf or +/-0)
//   overflow   exponent reached the all-ones field after rounding
//   underflow  exponent at or below zero after rounding; result flushed
// -----------------------------------------------------------------------------
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic                     sign,
  input  logic [FRAC_W-1:0]        frac,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed [EXP_W+1:0]  exp_in,
  output logic [EXP_W+FRAC_W:0]    result,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int E_W = EXP_W + 2;
  localparam logic signed [E_W-1:0] EXP_MAX  = E_W'((2 ** EXP_W) - 1);
  localparam logic signed [E_W-1:0] EXP_ZERO = '0;

  logic                  round_up;
  logic [FRAC_W:0]       frac_inc;
  logic signed [E_W-1:0] exp_fin;

  // Ties go to the even fraction: a halfway case only rounds up when LSB is 1.
  assign round_up = guard & (sticky | frac[0]);
  assign frac_inc = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};

  // A carry out of the fraction means the significand became 10.000...;
  // the low fraction bits are already zero, so only the exponent moves.
  assign exp_fin = exp_in + $signed({{(E_W-1){1'b0}}, frac_inc[FRAC_W]});

  assign overflow  = (exp_fin >= EXP_MAX);
  assign underflow = (exp_fin <= EXP_ZERO);

  always_comb begin
    if (overflow) begin
      result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (underflow) begin
      result = {sign, {(EXP_W+FRAC_W){1'b0}}};
    end else begin
      result = {sign, exp_fin[EXP_W-1:0], frac_inc[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/fp32_div_seq.sv
// -----------------------------------------------------------------------------
// fp32_div_seq
// Sequential IEEE-754 single-precision divider (FPU divide unit).
// Restoring radix-2 significand division producing one quotient bit per
// clock, followed by a round-to-nearest-even stage. Denormal inputs are
// treated as zero; underflowing results are flushed to zero.
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset (aborts any operation)
//   start             operand-valid pulse, only looked at while idle
//   A, B              dividend and divisor
//   busy              high from the cycle after start is accepted until done
//   done              one-cycle pulse; result and flags valid from then on
//   result            quotient, held until the next accepted start
//   overflow_flag     result overflowed to infinity
//   underflow_flag    result flushed to zero
//   div_by_zero_flag  finite nonzero divided by zero
//   invalid_flag      NaN operand, 0/0 or inf/inf
// Latency: special operands 2 cycles, normal operands 29 cycles.
// -----------------------------------------------------------------------------
module fp32_div_seq
  import fp_pkg::*;
#(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W,
  parameter int BIAS   = fp_pkg::BIAS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [EXP_W+FRAC_W:0] A,
  input  logic [EXP_W+FRAC_W:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [EXP_W+FRAC_W:0] result,
  output logic                  overflow_flag,
  output logic                  underflow_flag,
  output logic                  div_by_zero_flag,
  output logic                  invalid_flag
);

  localparam int DW     = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 1;           // significand with hidden bit
  localparam int R_W    = FRAC_W + 2;           // remainder, one bit headroom
  localparam int Q_W    = FRAC_W + 4;           // 1 int + FRAC_W + guard + 2 extra
  localparam int E_W    = EXP_W + 2;            // signed exponent headroom
  localparam int CNT_W  = $clog2(Q_W);

  // ---------------------------------------------------------------------------
  // Operand classification (combinational, used in the accept cycle)
  // ---------------------------------------------------------------------------
  fp_fields_t fa, fb;
  assign fa = fp_unpack(A);
  assign fb = fp_unpack(B);

  logic                  sign_in;
  logic                  is_special;
  logic                  spec_invalid;
  logic                  spec_dz;
  logic [DW-1:0]         spec_result;
  logic signed [E_W-1:0] exp_start;

  assign sign_in   = fa.sign ^ fb.sign;
  assign exp_start = $signed({2'b00, fa.expo}) - $signed({2'b00, fb.expo})
                   + $signed(E_W'(BIAS));

  // NOTE: every output of a combinational block is given a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    is_special   = fa.is_zero | fa.is_inf | fa.is_nan |
                   fb.is_zero | fb.is_inf | fb.is_nan;
    spec_invalid = 1'b0;
    spec_dz      = 1'b0;
    spec_result  = {sign_in, {(DW-1){1'b0}}};
    if (fa.is_nan || fb.is_nan || (fa.is_zero && fb.is_zero) ||
        (fa.is_inf && fb.is_inf)) begin
      spec_invalid = 1'b1;
      spec_result  = QNAN;
    end else if (fa.is_inf) begin
      // inf / finite (including inf / 0): signed infinity, no flag.
      spec_result = POS_INF | {sign_in, {(DW-1){1'b0}}};
    end else if (fb.is_zero) begin
      spec_dz     = 1'b1;
      spec_result = POS_INF | {sign_in, {(DW-1){1'b0}}};
    end
    // Remaining cases (0 / nonzero, finite / inf) keep the signed-zero default.
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                state, state_next;
  logic                  sign_q;
  logic [R_W-1:0]        rem_q;
  logic [MANT_W-1:0]     div_q;
  logic [Q_W-1:0]        quo_q;
  logic [CNT_W-1:0]      cnt_q;
  logic signed [E_W-1:0] exp_q;
  logic [DW-1:0]         spec_result_q;
  logic                  spec_invalid_q;
  logic                  spec_dz_q;

  // ---------------------------------------------------------------------------
  // One restoring-division step
  // ---------------------------------------------------------------------------
  logic           rem_ge;
  logic [R_W-2:0] rem_sub;

  assign rem_ge  = (rem_q >= {1'b0, div_q});
  // After a conditional subtract the remainder is below the divisor, so its
  // top bit is always clear and can be dropped before the left shift.
  assign rem_sub = rem_ge ? (R_W-1)'(rem_q - {1'b0, div_q}) : rem_q[R_W-2:0];

  // ---------------------------------------------------------------------------
  // Normalisation ahead of rounding
  // ---------------------------------------------------------------------------
  logic [FRAC_W-1:0]     frac_pre;
  logic                  guard_pre;
  logic                  sticky_pre;
  logic signed [E_W-1:0] exp_pre;
  logic                  rem_nz;
  logic [DW-1:0]         rnd_result;
  logic                  rnd_ovf;
  logic                  rnd_unf;

  assign rem_nz = |rem_q;

  // The quotient of two significands in [1,2) lies in (0.5,2): its MSB tells
  // whether a one-bit normalising shift (and exponent decrement) is needed.
  always_comb begin
    frac_pre   = quo_q[Q_W-2:3];
    guard_pre  = quo_q[2];
    sticky_pre = (|quo_q[1:0]) | rem_nz;
    exp_pre    = exp_q;
    if (!quo_q[Q_W-1]) begin
      frac_pre   = quo_q[Q_W-3:2];
      guard_pre  = quo_q[1];
      sticky_pre = quo_q[0] | rem_nz;
      exp_pre    = exp_q - E_W'(1);
    end
  end

  fp_round_rne #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .sign      (sign_q),
    .frac      (frac_pre),
    .guard     (guard_pre),
    .sticky    (sticky_pre),
    .exp_in    (exp_pre),
    .result    (rnd_result),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = is_special ? SPECIAL : DIVIDE;
      SPECIAL: state_next = IDLE;
      DIVIDE:  if (cnt_q == '0) state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      result           <= '0;
      overflow_flag    <= 1'b0;
      underflow_flag   <= 1'b0;
      div_by_zero_flag <= 1'b0;
      invalid_flag     <= 1'b0;
      sign_q           <= 1'b0;
      rem_q            <= '0;
      div_q            <= '0;
      quo_q            <= '0;
      cnt_q            <= '0;
      exp_q            <= '0;
      spec_result_q    <= '0;
      spec_invalid_q   <= 1'b0;
      spec_dz_q        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy             <= 1'b1;
            result           <= '0;
            overflow_flag    <= 1'b0;
            underflow_flag   <= 1'b0;
            div_by_zero_flag <= 1'b0;
            invalid_flag     <= 1'b0;
            sign_q           <= sign_in;
            rem_q            <= {2'b01, fa.frac};
            div_q            <= {1'b1, fb.frac};
            quo_q            <= '0;
            cnt_q            <= CNT_W'(Q_W - 1);
            exp_q            <= exp_start;
            spec_result_q    <= spec_result;
            spec_invalid_q   <= spec_invalid;
            spec_dz_q        <= spec_dz;
          end
        end
        SPECIAL: begin
          result           <= spec_result_q;
          invalid_flag     <= spec_invalid_q;
          div_by_zero_flag <= spec_dz_q;
          done             <= 1'b1;
          busy             <= 1'b0;
        end
        DIVIDE: begin
          rem_q <= {rem_sub, 1'b0};
          quo_q <= {quo_q[Q_W-2:0], rem_ge};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        ROUND: begin
          result         <= rnd_result;
          overflow_flag  <= rnd_ovf;
          underflow_flag <= rnd_unf;
          done           <= 1'b1;
          busy           <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_seq.sv
// -----------------------------------------------------------------------------
// tb_fp32_div_seq
// Directed self-checking bench for fp32_div_seq. Latency is counted as the
// number of rising edges from the edge that samples start up to and
// including the edge at which done is first seen high.
// Flags are compared as {overflow, underflow, div_by_zero, invalid}.
// -----------------------------------------------------------------------------
module tb_fp32_div_seq;

  localparam int LAT_LIMIT = 60;
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_OVF  = 4'b1000;
  localparam logic [3:0] F_UNF  = 4'b0100;
  localparam logic [3:0] F_DZ   = 4'b0010;
  localparam logic [3:0] F_INV  = 4'b0001;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow_flag;
  logic        underflow_flag;
  logic        div_by_zero_flag;
  logic        invalid_flag;

  int n_tests = 0;
  int n_fail  = 0;

  fp32_div_seq dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .A                (op_a),
    .B                (op_b),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .overflow_flag    (overflow_flag),
    .underflow_flag   (underflow_flag),
    .div_by_zero_flag (div_by_zero_flag),
    .invalid_flag     (invalid_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] flags_now();
    return {28'd0, overflow_flag, underflow_flag, div_by_zero_flag, invalid_flag};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands at a falling edge, let the next rising edge sample start,
  // then drop start. Returns 1 time unit after the sampling edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags);
    int   lat;
    logic busy_ok;
    start_op(a, b);
    wait_done(lat, busy_ok);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, result, exp_res);
    check({tag, ".flags"}, flags_now(), {28'd0, exp_flags});
    check({tag, ".busy_during"}, {31'd0, busy_ok}, 32'd1);
    check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".done_width"}, {31'd0, done}, 32'd0);
    check({tag, ".result_held"}, result, exp_res);
  endtask

  initial begin
    int   lat;
    int   n_done;
    logic busy_ok;

    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #12;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.result", result, 32'h0);
    check("reset.flags", flags_now(), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Normal operands
    run_op("div_6_2",  32'h40C0_0000, 32'h4000_0000, 29, 32'h4040_0000, F_NONE);
    run_op("div_1_3",  32'h3F80_0000, 32'h4040_0000, 29, 32'h3EAA_AAAB, F_NONE);

    // Special operands
    run_op("m1_div_0",  32'hBF80_0000, 32'h0000_0000, 2, 32'hFF80_0000, F_DZ);
    run_op("0_div_0",   32'h0000_0000, 32'h0000_0000, 2, 32'h7FC0_0000, F_INV);
    run_op("inf_div_inf", 32'h7F80_0000, 32'h7F80_0000, 2, 32'h7FC0_0000, F_INV);
    run_op("2_div_inf", 32'h4000_0000, 32'h7F80_0000, 2, 32'h0000_0000, F_NONE);

    // Boundaries
    run_op("overflow",  32'h7F7F_FFFF, 32'h3F00_0000, 29, 32'h7F80_0000, F_OVF);
    run_op("underflow", 32'h0080_0000, 32'h4000_0000, 29, 32'h0000_0000, F_UNF);
    run_op("denormal",  32'h0040_0000, 32'h3F80_0000, 2,  32'h0000_0000, F_NONE);

    // start while busy is ignored
    start_op(32'h40C0_0000, 32'h4000_0000);
    repeat (4) @(posedge clk);
    #1;
    op_a  = 32'h3F80_0000;
    op_b  = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, busy_ok);
    check("busy_start.latency", 32'(lat), 32'd24);
    check("busy_start.result", result, 32'h4040_0000);
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    check("busy_start.extra_done", 32'(n_done), 32'd0);

    // Reset in the middle of DIVIDE aborts with no done pulse
    start_op(32'h40C0_0000, 32'h4000_0000);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.done", {31'd0, done}, 32'd0);
    check("abort.result", result, 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    check("abort.no_done", 32'(n_done), 32'd0);
    run_op("after_abort", 32'h4120_0000, 32'h40A0_0000, 29, 32'h4000_0000, F_NONE);

    // Back-to-back: new start presented in the done cycle is accepted
    start_op(32'h40C0_0000, 32'h4000_0000);
    wait_done(lat, busy_ok);
    check("b2b.first_latency", 32'(lat), 32'd29);
    check("b2b.first_result", result, 32'h4040_0000);
    op_a  = 32'h4120_0000;
    op_b  = 32'h40A0_0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b.accept_busy", {31'd0, busy}, 32'd1);
    check("b2b.accept_done", {31'd0, done}, 32'd0);
    check("b2b.accept_cleared", result, 32'h0);
    wait_done(lat, busy_ok);
    check("b2b.second_latency", 32'(lat), 32'd29);
    check("b2b.second_result", result, 32'h4000_0000);
    check("b2b.second_flags", flags_now(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
- Sequential IEEE-754 single-precision divider. It is the inverse-operation companion to the team's floating-point multiplier datapath.
- Accepts operands A and B on a start pulse and computes A/B with a restoring radix-2 significand divider, one quotient bit per cycle.
- Rounds round-to-nearest-even and reports exception flags.
- Sits beside the multiplier behind the same start/done-style control, as the FPU's divide unit.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, stored fraction width
BIAS, 127, exponent bias (verification at defaults only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  operand-valid pulse, sampled only in IDLE
A  in  32  dividend, IEEE-754 single
B  in  32  divisor, IEEE-754 single
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; result and flags valid from this cycle
result  out  32  quotient; held until the next accepted start
overflow_flag  out  1  result overflowed to infinity
underflow_flag  out  1  result flushed to zero
div_by_zero_flag  out  1  finite nonzero divided by zero
invalid_flag  out  1  NaN operand, 0/0, or inf/inf

Behaviour:
- Reset (async, active-high): state=IDLE; busy, done, result and all flags = 0. Reset mid-operation aborts the operation, with no done pulse.
- Unpack:
  - sign = sA^sB.
  - exp field 0 = zero (denormals flushed to zero, no flag).
  - exp field 255 with frac≠0 = NaN; with frac=0 = infinity.
- States: IDLE, SPECIAL, DIVIDE, ROUND.
- IDLE:
  - Accept start: capture operands; clear flags; busy←1.
  - If any special case applies → SPECIAL; else → DIVIDE with iteration counter = 26.
  - Remainder R ← {1'b0,1,fracA} (25b); divisor D ← {1,fracB}; Q ← 0.
  - Exponent E ← eA − eB + BIAS, in 10-bit signed arithmetic.
- SPECIAL (1 cycle):
  - NaN operand, 0/0 or inf/inf → result 0x7FC00000, invalid_flag.
  - Finite nonzero / 0 → ±inf, div_by_zero_flag.
  - inf/finite → ±inf, no flag.
  - 0/nonzero and finite/inf → ±0, no flag.
  - Then done=1, busy←0, → IDLE. Latency: done is high 2 cycles after the start edge.
- DIVIDE (27 cycles):
  - Each cycle: if R≥D, then Qbit=1 and R←R−D, else Qbit=0.
  - Q←{Q[25:0],Qbit}; R←R<<1; counter decrements; at 0 → ROUND.
- ROUND (1 cycle):
  - If Q[26]: mant=Q[26:3], G=Q[2], S=|Q[1:0] | (R≠0).
  - Else: mant=Q[25:2], G=Q[1], S=Q[0] | (R≠0), and E←E−1.
  - Round up if G & (S | mant[0]). A mantissa carry-out sets mant=1.0 and E←E+1.
  - If E≥255 → ±inf (0x7F800000 | sign), overflow_flag.
  - If E≤0 → ±0, underflow_flag.
  - Otherwise result = {sign, E[7:0], mant[22:0]}.
  - done=1, busy←0, → IDLE.
- Latency, normal path: done is high 29 cycles after the start edge.
- start while busy: ignored, with no effect on the operation in flight.
- start in the cycle done is high: accepted (state is IDLE), so back-to-back throughput is 1 op per 29 cycles.
- done is exactly one cycle wide. result and flags are stable from done until the next accepted start clears them.

Decomposition:
- Shared package fp_pkg: BIAS, EXP_W, FRAC_W, QNAN=32'h7FC00000, POS_INF=32'h7F800000, state enum, and an unpack-field helper function shared with the multiplier.
- Natural sub-module: fp_round_rne (combinational mant/G/S/E → packed result plus overflow/underflow).
- Counter and FSM stay in the top.

Test Plan:
1. A=0x40C00000 (6.0), B=0x40000000 (2.0), start → done 29 cycles later, result=0x40400000, all flags 0, busy high for the intervening cycles.
2. A=0x3F800000, B=0x40400000 (1/3) → result=0x3EAAAAAB (RNE round-up), flags 0.
3. Specials, each with done 2 cycles after start:
   - A=0xBF800000, B=0x00000000 → 0xFF800000 with div_by_zero_flag.
   - 0/0 → 0x7FC00000 with invalid_flag.
   - A=0x7F800000/0x7F800000 → 0x7FC00000 with invalid_flag.
   - A=0x40000000, B=0x7F800000 → 0x00000000.
4. Boundaries:
   - A=0x7F7FFFFF, B=0x3F000000 → 0x7F800000 with overflow_flag.
   - A=0x00800000, B=0x40000000 → 0x00000000 with underflow_flag.
   - A=0x00400000 (denormal), B=0x3F800000 → 0x00000000 with no flags.
5. Handshake:
   - Start 6/2, pulse start again at cycle 5 with other operands → only one done, result 0x40400000.
   - Restart with reset asserted at cycle 10 of DIVIDE → busy, done and result 0 with no done pulse; the next start completes normally.
6. Back-to-back: assert start with new operands (A=0x41200000, B=0x40A00000) during the done cycle → accepted; second done 29 cycles later with result=0x40000000.
